// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: sequencer state encoding,
// default PC width and the reset fetch vector.
package pc_sequencer_pkg;
  localparam int PC_W_DEF  = 16;
  localparam int RESET_VEC = 0;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_FLUSH
  } seq_state_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between execute / instruction memory and the PC sequencer.
//   slave  : sequencer side (takes the branch decision, drives pc/flush/pulses)
//   master : environment side (execute stage + imem port)
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);
  logic            stall;
  logic            imem_ready;
  logic            branch;
  logic [PC_W-1:0] offset;
  logic            is_call;
  logic            is_ret;
  logic [PC_W-1:0] pc;
  logic            fetch_valid;
  logic            flush;
  logic            ras_overflow;
  logic            ras_underflow;

  modport slave (
    input  stall, imem_ready, branch, offset, is_call, is_ret,
    output pc, fetch_valid, flush, ras_overflow, ras_underflow
  );

  modport master (
    output stall, imem_ready, branch, offset, is_call, is_ret,
    input  pc, fetch_valid, flush, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack.
//   push/pop : one operation per cycle (push wins if both asserted)
//   wdata    : return address to push
//   top      : most recently pushed entry (valid when !empty)
//   full/empty : occupancy flags
// A push while full overwrites the oldest entry: the write slot is the one
// after the newest, which on a full ring is exactly the oldest.
module ras_stack
  import pc_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = PC_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DEPTH-1:0][W-1:0]   mem_q;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign top   = mem_q[ptr_q - PTR_W'(1)];

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries are never cleared; a zero count makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= wdata;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of pc_sequencer_if (execute decision in, fetch
//              address / flush / RAS error pulses out)
// Owns the PC and return-address stack, redirects on taken branches and
// holds flush for FLUSH_CYCLES unstalled cycles after each redirect.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W         = PC_W_DEF,
  parameter int RAS_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  pc_sequencer_if.slave     bus
);
  localparam int              CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             flush_q, flush_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             ras_push, ras_pop, ras_full, ras_empty;
  logic [PC_W-1:0]  ras_top;

  ras_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .wdata (pc_q + PC_W'(1)),
    .top   (ras_top),
    .full  (ras_full),
    .empty (ras_empty)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;  // leaves boot even under stall
      ST_RUN: if (!bus.stall) begin
        if (bus.branch) begin
          // Redirect ignores imem_ready: the old fetch is wrong-path anyway.
          state_d = ST_FLUSH;
          cnt_d   = CNT_LOAD;
          pc_d    = bus.offset;
          if (bus.is_ret) begin
            if (!ras_empty) begin
              pc_d    = ras_top;
              ras_pop = 1'b1;
            end else begin
              unf_d   = 1'b1;
            end
          end else if (bus.is_call) begin
            ras_push = 1'b1;
            ovf_d    = ras_full;
          end
        end else if (bus.imem_ready) begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      ST_FLUSH: if (!bus.stall) begin
        if (bus.imem_ready) pc_d = pc_q + PC_W'(1);
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_BOOT;
    endcase
    fetch_valid_d = (state_d != ST_BOOT);
    flush_d       = (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= PC_W'(RESET_VEC);
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.fetch_valid   = fetch_valid_q;
  assign bus.flush         = flush_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam int DEPTH = 4;
  localparam int FC    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(16)) bus ();

  pc_sequencer #(.PC_W(16), .RAS_DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: fetch address, boot flag, remaining flush cycles and
  // the return stack as a queue (back = newest).
  logic [15:0] m_pc;
  bit          m_boot;
  int          m_fl;
  logic [15:0] m_ras[$];
  bit          m_ovf, m_unf;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0; m_boot = 1'b1; m_fl = 0; m_ovf = 0; m_unf = 0;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic [15:0] tgt;
    m_ovf = 0; m_unf = 0;
    if (m_boot) m_boot = 0;
    else if (bus.stall) begin end
    else if (m_fl > 0) begin
      m_fl--;
      if (bus.imem_ready) m_pc = m_pc + 16'd1;
    end else if (bus.branch) begin
      tgt = bus.offset;
      if (bus.is_ret) begin
        if (m_ras.size() > 0) tgt = m_ras.pop_back();
        else m_unf = 1;
      end else if (bus.is_call) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1;
        end
        m_ras.push_back(m_pc + 16'd1);
      end
      m_pc = tgt;
      m_fl = FC;
    end else if (bus.imem_ready) m_pc = m_pc + 16'd1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("pc",            {16'h0, bus.pc},       {16'h0, m_pc});
      check("fetch_valid",   32'(bus.fetch_valid),  32'(!m_boot));
      check("flush",         32'(bus.flush),        32'(m_fl > 0));
      check("ras_overflow",  32'(bus.ras_overflow), 32'(m_ovf));
      check("ras_underflow", 32'(bus.ras_underflow),32'(m_unf));
    end
  end

  // Drive one cycle's inputs at a negedge, return at the following negedge.
  task automatic cyc(input bit s, input bit ir, input bit br, input bit c,
                     input bit r, input logic [15:0] off);
    bus.stall = s; bus.imem_ready = ir; bus.branch = br;
    bus.is_call = c; bus.is_ret = r; bus.offset = off;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 16'h0);
  endtask

  // Async reset asserted mid-cycle, released on the next negedge.
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_pc",    {16'h0, bus.pc}, 32'h0);
    check("rst_flush", 32'(bus.flush), 32'h0);
    check("rst_fv",    32'(bus.fetch_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 0; bus.imem_ready = 1; bus.branch = 0;
    bus.is_call = 0; bus.is_ret = 0; bus.offset = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_pc", {16'h0, bus.pc}, 32'h0);
    check("reset_fv", 32'(bus.fetch_valid), 32'h0);
    rst = 1'b0;

    // Boot then sequential fetch 0,1,2,3
    idle(1);
    check("boot_pc0", {16'h0, bus.pc}, 32'h0);
    check("boot_fv",  32'(bus.fetch_valid), 32'h1);
    idle(3);
    check("seq_pc3", {16'h0, bus.pc}, 32'h3);

    // Branch at 0x0010 to 0x0200; branches during flush ignored
    for (int i = 0; i < 40 && m_pc != 16'h0010; i++) idle(1);
    check("at_0010", {16'h0, bus.pc}, 32'h0010);
    cyc(0, 1, 1, 0, 0, 16'h0200);
    check("redir_pc",    {16'h0, bus.pc}, 32'h0200);
    check("redir_flush", 32'(bus.flush), 32'h1);
    cyc(0, 1, 1, 0, 0, 16'h0555);
    check("fl_pc1", {16'h0, bus.pc}, 32'h0201);
    cyc(0, 1, 1, 0, 0, 16'h0777);
    check("fl_pc2",    {16'h0, bus.pc}, 32'h0202);
    check("fl_done",   32'(bus.flush), 32'h0);
    idle(1);

    // Call at 0x0040, return with bogus offset
    cyc(0, 1, 1, 0, 0, 16'h003E);
    idle(2);
    check("at_0040", {16'h0, bus.pc}, 32'h0040);
    cyc(0, 1, 1, 1, 0, 16'h0300);
    check("call_pc", {16'h0, bus.pc}, 32'h0300);
    idle(2);
    cyc(0, 1, 1, 0, 1, 16'hFFFF);
    check("ret_pc",  {16'h0, bus.pc}, 32'h0041);
    check("ret_unf", 32'(bus.ras_underflow), 32'h0);
    idle(2);

    // Five nested calls, then five returns
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 1, 1, 1, 0, 16'(k * 16'h1000));
      if (k == 5) check("ovf_5th", 32'(bus.ras_overflow), 32'h1);
      idle(2);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 1, 1, 0, 1, (k == 5) ? 16'h0ABC : 16'h0EEE);
      if (k == 1) check("ret1_pc", {16'h0, bus.pc}, 32'h4003);
      if (k == 4) check("ret4_pc", {16'h0, bus.pc}, 32'h1003);
      if (k == 5) begin
        check("ret5_pc",  {16'h0, bus.pc}, 32'h0ABC);
        check("ret5_unf", 32'(bus.ras_underflow), 32'h1);
      end
      idle(2);
    end

    // Stall during flush, then imem_ready low
    cyc(0, 1, 1, 0, 0, 16'h0500);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 0, 0, 16'h0999);
      check("stall_pc",    {16'h0, bus.pc}, 32'h0500);
      check("stall_flush", 32'(bus.flush), 32'h1);
    end
    cyc(0, 1, 0, 0, 0, 16'h0);
    check("post_stall_flush", 32'(bus.flush), 32'h1);
    cyc(0, 1, 0, 0, 0, 16'h0);
    check("post_stall_pc",  {16'h0, bus.pc}, 32'h0502);
    check("post_stall_end", 32'(bus.flush), 32'h0);
    cyc(0, 0, 0, 0, 0, 16'h0);
    cyc(0, 0, 0, 0, 0, 16'h0);
    check("imem_hold_pc", {16'h0, bus.pc}, 32'h0502);
    check("imem_hold_fv", 32'(bus.fetch_valid), 32'h1);

    // Reset mid-flush with two RAS entries
    cyc(0, 1, 1, 1, 0, 16'h0600); idle(2);
    cyc(0, 1, 1, 1, 0, 16'h0650); idle(2);
    cyc(0, 1, 1, 0, 0, 16'h0700);
    do_reset();
    idle(1);
    cyc(0, 1, 1, 0, 1, 16'h0123);
    check("rst_ret_pc",  {16'h0, bus.pc}, 32'h0123);
    check("rst_ret_unf", 32'(bus.ras_underflow), 32'h1);
    idle(2);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 80,
               $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 45,
               $urandom_range(0, 99) < 35, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
